cv32e40x_xif_aes_ooq: RTL



---
 rtl/cv32e40x_xif_aes_ooq_if.sv | 44 ++++
 rtl/cv32e40x_xif_aes_ooq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_xif_aes_ooq_if.sv
// eXtension-interface bundle between the cv32e40x core and the AES
// coprocessor: issue, commit and result channels.
`timescale 1ns/1ps

interface cv32e40x_xif_aes_ooq_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_instr;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic [2*XLEN-1:0]     issue_rs;
  logic [1:0]            issue_rs_valid;
  logic                  issue_accept;
  logic                  issue_writeback;

  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;

  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [XLEN-1:0]       result_data;
  logic [4:0]            result_rd;
  logic                  result_we;

  // core side
  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
    output commit_valid, commit_id, commit_kill, result_ready,
    input  issue_ready, issue_accept, issue_writeback,
    input  result_valid, result_id, result_data, result_rd, result_we
  );

  // coprocessor side
  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs, issue_rs_valid,
    input  commit_valid, commit_id, commit_kill, result_ready,
    output issue_ready, issue_accept, issue_writeback,
    output result_valid, result_id, result_data, result_rd, result_we
  );
endinterface

// File: rtl/cv32e40x_xif_aes_ooq.sv
// AES32 XIF coprocessor: computes aes32{e,d}s{,m}i in the issue cycle and
// parks each result in an in-order tracking queue until commit or kill.
// Optional macro XIF_AES_DEC_EN adds the decrypt ops (dsi/dsmi); without it
// those encodings are treated as non-AES.
//
// Entry states:
//   state     | meaning
//   FREE      | slot unused
//   PEND      | issued, waiting for commit/kill
//   READY     | committed, result waiting to be taken at head
//   KILLED    | killed, dropped silently once it reaches head
`timescale 1ns/1ps

module cv32e40x_xif_aes_ooq #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4
) (
  input logic                   clk,
  input logic                   rst,
  cv32e40x_xif_aes_ooq_if.slave xif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_READY, ST_KILLED} ent_state_e;

  ent_state_e            st_q [DEPTH];
  ent_state_e            st_d [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q [DEPTH];
  logic [4:0]            rd_q [DEPTH];
  logic [XLEN-1:0]       data_q [DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      cnt_q;

  logic full, is_aes, issue_rdy, issue_hs, same_commit, alloc, retire, head_rdy;
  logic [4:0]      f5, shamt;
  logic [7:0]      si, so_e;
  logic [31:0]     mix;
  logic [63:0]     mix_rot;
  logic [XLEN-1:0] aes_result;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] a;
    a = gf_inv(x);
    return a ^ rol8(a, 1) ^ rol8(a, 2) ^ rol8(a, 3) ^ rol8(a, 4) ^ 8'h63;
  endfunction

`ifdef XIF_AES_DEC_EN
  logic [7:0] so_d;

  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    return gf_inv(rol8(y, 1) ^ rol8(y, 3) ^ rol8(y, 6) ^ 8'h05);
  endfunction
`endif

  // decode and issue handshake
  always_comb begin
    f5     = xif.issue_instr[29:25];
    is_aes = 1'b0;
    if (xif.issue_instr[6:0] == 7'b0110011 && xif.issue_instr[14:12] == 3'b000) begin
`ifdef XIF_AES_DEC_EN
      is_aes = (f5 == 5'b10001) || (f5 == 5'b10011) || (f5 == 5'b10101) || (f5 == 5'b10111);
`else
      is_aes = (f5 == 5'b10001) || (f5 == 5'b10011);
`endif
    end
    issue_rdy = !full && (!is_aes || xif.issue_rs_valid == 2'b11);
    issue_hs  = xif.issue_valid && issue_rdy && is_aes;
  end

  assign full                = (cnt_q == CNT_W'(DEPTH));
  assign xif.issue_ready     = issue_rdy;
  assign xif.issue_accept    = is_aes;
  assign xif.issue_writeback = is_aes;

  // AES32 datapath: one S-box lookup on byte bs of rs2, rotated into place, xor rs1
  always_comb begin
    shamt = {xif.issue_instr[31:30], 3'b000};
    si    = xif.issue_rs[XLEN + 32'(shamt) +: 8];
    so_e  = sbox_fwd(si);
    mix   = 32'h0;
`ifdef XIF_AES_DEC_EN
    so_d  = sbox_inv(si);
`endif
    case (f5)
      5'b10001: mix = {24'h0, so_e};
      5'b10011: mix = {gf_mul(so_e, 8'h03), so_e, so_e, xtime(so_e)};
`ifdef XIF_AES_DEC_EN
      5'b10101: mix = {24'h0, so_d};
      5'b10111: mix = {gf_mul(so_d, 8'h0b), gf_mul(so_d, 8'h0d),
                       gf_mul(so_d, 8'h09), gf_mul(so_d, 8'h0e)};
`endif
      default:  mix = 32'h0;
    endcase
    mix_rot    = {mix, mix} << shamt;
    aes_result = xif.issue_rs[XLEN-1:0] ^ mix_rot[63:32];
  end

  // entry next-state: commit/kill lookup, head retirement, allocation at tail
  always_comb begin
    st_d        = st_q;
    alloc       = 1'b0;
    retire      = 1'b0;
    head_rdy    = (st_q[head_q] == ST_READY);
    same_commit = xif.commit_valid && (xif.commit_id == xif.issue_id);
    for (int i = 0; i < DEPTH; i++) begin
      if (xif.commit_valid && st_q[i] == ST_PEND && id_q[i] == xif.commit_id)
        st_d[i] = xif.commit_kill ? ST_KILLED : ST_READY;
    end
    if ((head_rdy && xif.result_ready) || st_q[head_q] == ST_KILLED) begin
      st_d[head_q] = ST_FREE;
      retire       = 1'b1;
    end
    // a kill that lands on the issuing id means the slot is never taken
    if (issue_hs && !(same_commit && xif.commit_kill)) begin
      alloc        = 1'b1;
      st_d[tail_q] = same_commit ? ST_READY : ST_PEND;
    end
  end

  // queue state, payload and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= ST_FREE;
        id_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q <= st_d;
      if (alloc) begin
        id_q[tail_q]   <= xif.issue_id;
        rd_q[tail_q]   <= xif.issue_instr[11:7];
        data_q[tail_q] <= aes_result;
        tail_q         <= tail_q + PTR_W'(1);
      end
      if (retire) head_q <= head_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(alloc) - CNT_W'(retire);
    end
  end

  assign xif.result_valid = head_rdy;
  assign xif.result_we    = head_rdy;
  assign xif.result_id    = head_rdy ? id_q[head_q]   : '0;
  assign xif.result_rd    = head_rdy ? rd_q[head_q]   : '0;
  assign xif.result_data  = head_rdy ? data_q[head_q] : '0;

endmodule
